// File: rtl/alu_seq_pkg.sv
// Shared types for the sequential ALU: operation codes, flag layout and FSM states.
package alu_seq_pkg;

  typedef enum logic [3:0] {
    OpAdd  = 4'd0,
    OpAddc = 4'd1,
    OpSub  = 4'd2,
    OpSubb = 4'd3,
    OpSll  = 4'd4,
    OpSrl  = 4'd5,
    OpSra  = 4'd6,
    OpAnd  = 4'd7,
    OpOr   = 4'd8,
    OpXor  = 4'd9,
    OpNot  = 4'd10,
    OpMul  = 4'd11
  } alu_op_e;

  // Packed so that the flags output reads {C,Z,N,V} from MSB to LSB.
  typedef struct packed {
    logic c;
    logic z;
    logic n;
    logic v;
  } alu_flags_t;

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StBusy = 1'b1;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative unsigned shift-add multiplier, one multiplier bit per cycle.
module alu_mul_iter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic                 hold_i,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  output logic                 done_o,
  output logic [2*WIDTH-1:0]   prod_o
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0] prod_q, prod_d, prod_next;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               active_q, active_d;
  logic               fin_q, fin_d;
  logic               last;
  logic [WIDTH:0]     partial;

  assign last    = (cnt_q == CntW'(WIDTH - 1));
  // High half accumulates the multiplicand, then the whole product shifts right.
  assign partial   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
  assign prod_next = {partial, prod_q[WIDTH-1:1]};

  always_comb begin
    active_d = active_q;
    fin_d    = fin_q;
    cnt_d    = cnt_q;
    prod_d   = prod_q;
    mcand_d  = mcand_q;
    if (start_i) begin
      active_d = 1'b1;
      fin_d    = 1'b0;
      cnt_d    = '0;
      prod_d   = {{WIDTH{1'b0}}, b_i};
      mcand_d  = a_i;
    end else if (active_q && !fin_q) begin
      prod_d = prod_next;
      cnt_d  = cnt_q + 1'b1;
      if (last) begin
        if (hold_i) begin
          fin_d = 1'b1;
        end else begin
          active_d = 1'b0;
        end
      end
    end else if (fin_q && !hold_i) begin
      active_d = 1'b0;
      fin_d    = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      active_q <= 1'b0;
      fin_q    <= 1'b0;
      cnt_q    <= '0;
      prod_q   <= '0;
      mcand_q  <= '0;
    end else begin
      active_q <= active_d;
      fin_q    <= fin_d;
      cnt_q    <= cnt_d;
      prod_q   <= prod_d;
      mcand_q  <= mcand_d;
    end
  end

  // Final product is offered combinationally on the last iteration, or from the
  // register while the consumer slot is still occupied.
  assign done_o = active_q && (fin_q || last);
  assign prod_o = fin_q ? prod_q : prod_next;

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshake, persistent C/Z/N/V flags and iterative MUL.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SHW   = $clog2(WIDTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [3:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             flag_clr_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_o,
  output logic [WIDTH-1:0] out_hi_o,
  output logic [3:0]       flags_o,
  output logic             busy_o
);

  localparam logic [SHW-1:0] ShLimit = SHW'(WIDTH);

  logic [0:0]         state_q, state_d;
  logic [WIDTH-1:0]   out_q, out_d;
  logic [WIDTH-1:0]   out_hi_q, out_hi_d;
  alu_flags_t         flags_q, flags_d;
  logic               out_valid_q, out_valid_d;

  alu_op_e            op;
  alu_flags_t         flags_base, res_flags;
  logic               accept, consume, clr_eff, hold;
  logic               mul_start, mul_done;
  logic [2*WIDTH-1:0] mul_prod;
  logic [WIDTH-1:0]   res;
  logic [WIDTH:0]     arith;
  logic [SHW-1:0]     sh;
  logic               sh_sat;
  logic               op_known;
  logic signed [WIDTH-1:0] sra_res;

  assign op         = alu_op_e'(op_i);
  assign in_ready_o = (state_q == StIdle) && (!out_valid_q || out_ready_i);
  assign accept     = in_valid_i && in_ready_o;
  assign consume    = out_valid_q && out_ready_i;
  assign hold       = out_valid_q && !out_ready_i;
  // A clear is dropped while an unconsumed result must keep its flags stable.
  assign clr_eff    = flag_clr_i && !hold;
  assign flags_base = clr_eff ? '0 : flags_q;
  assign mul_start  = accept && (op == OpMul);

  assign sh      = b_i[SHW-1:0];
  assign sh_sat  = (sh >= ShLimit);
  assign sra_res = $signed(a_i) >>> sh;

  alu_mul_iter #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .start_i(mul_start),
    .hold_i (hold),
    .a_i    (a_i),
    .b_i    (b_i),
    .done_o (mul_done),
    .prod_o (mul_prod)
  );

  // Single-cycle datapath; C and V default to "unchanged" and "clear" respectively.
  always_comb begin
    res       = '0;
    arith     = '0;
    op_known  = 1'b1;
    res_flags = flags_base;
    res_flags.v = 1'b0;
    case (op)
      OpAdd, OpAddc: begin
        arith = {1'b0, a_i} + {1'b0, b_i} +
                {{WIDTH{1'b0}}, (op == OpAddc) && flags_base.c};
        res = arith[WIDTH-1:0];
        res_flags.c = arith[WIDTH];
        res_flags.v = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (res[WIDTH-1] != a_i[WIDTH-1]);
      end
      OpSub, OpSubb: begin
        arith = {1'b0, a_i} - {1'b0, b_i} -
                {{WIDTH{1'b0}}, (op == OpSubb) && flags_base.c};
        res = arith[WIDTH-1:0];
        res_flags.c = arith[WIDTH];
        res_flags.v = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (res[WIDTH-1] != a_i[WIDTH-1]);
      end
      OpSll:   res = sh_sat ? '0 : (a_i << sh);
      OpSrl:   res = sh_sat ? '0 : (a_i >> sh);
      OpSra:   res = sh_sat ? {WIDTH{a_i[WIDTH-1]}} : sra_res;
      OpAnd:   res = a_i & b_i;
      OpOr:    res = a_i | b_i;
      OpXor:   res = a_i ^ b_i;
      OpNot:   res = ~a_i;
      OpMul:   res = '0;
      default: begin
        res       = '0;
        op_known  = 1'b0;
        res_flags = flags_base;
      end
    endcase
    if (op_known) begin
      res_flags.z = (res == '0);
      res_flags.n = res[WIDTH-1];
    end else begin
      res_flags.z = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    out_d       = out_q;
    out_hi_d    = out_hi_q;
    flags_d     = flags_q;
    out_valid_d = out_valid_q;
    if (consume) begin
      out_valid_d = 1'b0;
    end
    if (clr_eff) begin
      flags_d = '0;
    end
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (op == OpMul) begin
            state_d = StBusy;
          end else begin
            out_d       = res;
            out_hi_d    = '0;
            flags_d     = res_flags;
            out_valid_d = 1'b1;
          end
        end
      end
      StBusy: begin
        if (mul_done && !hold) begin
          out_d       = mul_prod[WIDTH-1:0];
          out_hi_d    = mul_prod[2*WIDTH-1:WIDTH];
          flags_d.c   = |mul_prod[2*WIDTH-1:WIDTH];
          flags_d.z   = (mul_prod[WIDTH-1:0] == '0);
          flags_d.n   = mul_prod[WIDTH-1];
          flags_d.v   = 1'b0;
          out_valid_d = 1'b1;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      out_q       <= '0;
      out_hi_q    <= '0;
      flags_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_q       <= out_d;
      out_hi_q    <= out_hi_d;
      flags_q     <= flags_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_o       = out_q;
  assign out_hi_o    = out_hi_q;
  assign flags_o     = flags_q;
  assign out_valid_o = out_valid_q;
  assign busy_o      = (state_q == StBusy);

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq (WIDTH=8): directed vectors, monitor pops on each handshake.
module tb_alu_seq;

  localparam logic [3:0] OpAdd = 4'd0, OpAddc = 4'd1, OpSub = 4'd2, OpSubb = 4'd3;
  localparam logic [3:0] OpSll = 4'd4, OpSrl = 4'd5, OpSra = 4'd6, OpAnd = 4'd7;
  localparam logic [3:0] OpOr = 4'd8, OpXor = 4'd9, OpNot = 4'd10, OpMul = 4'd11;
  localparam logic [3:0] OpUndef = 4'd12;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       in_valid_i = 1'b0;
  logic       flag_clr_i = 1'b0;
  logic       out_ready_i = 1'b1;
  logic [3:0] op_i = 4'd0;
  logic [7:0] a_i = 8'd0;
  logic [7:0] b_i = 8'd0;
  logic       in_ready_o, out_valid_o, busy_o;
  logic [7:0] out_o, out_hi_o;
  logic [3:0] flags_o;

  typedef struct {
    string      name;
    logic [7:0] out;
    logic [7:0] hi;
    logic [3:0] fl;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;

  alu_seq #(
    .WIDTH(8)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .op_i       (op_i),
    .a_i        (a_i),
    .b_i        (b_i),
    .flag_clr_i (flag_clr_i),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .out_o      (out_o),
    .out_hi_o   (out_hi_o),
    .flags_o    (flags_o),
    .busy_o     (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted result must match the oldest outstanding expectation.
  always @(negedge clk_i) begin
    if (rst_ni && out_valid_o && out_ready_i) begin
      if (sbq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_result: got out=0x%0h, want no result", out_o);
      end else begin
        mon_e = sbq.pop_front();
        chk({mon_e.name, ".out"}, {24'd0, out_o}, {24'd0, mon_e.out});
        chk({mon_e.name, ".out_hi"}, {24'd0, out_hi_o}, {24'd0, mon_e.hi});
        chk({mon_e.name, ".flags"}, {28'd0, flags_o}, {28'd0, mon_e.fl});
      end
    end
  end

  task automatic issue(input string name, input logic [3:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic [7:0] eo, input logic [7:0] eh,
                       input logic [3:0] ef, input logic clr, input logic push);
    int   waited = 0;
    exp_t e;
    op_i       = op;
    a_i        = a;
    b_i        = b;
    flag_clr_i = clr;
    in_valid_i = 1'b1;
    @(negedge clk_i);
    while (!in_ready_o && waited < 100) begin
      @(negedge clk_i);
      waited++;
    end
    if (!in_ready_o) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s.accept: got in_ready=0 for 100 cycles, want 1", name);
    end else if (push) begin
      e.name = name;
      e.out  = eo;
      e.hi   = eh;
      e.fl   = ef;
      sbq.push_back(e);
    end
    @(posedge clk_i);
    #1;
    in_valid_i = 1'b0;
    flag_clr_i = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    @(negedge clk_i);
    while (out_valid_o && k < 50) begin
      @(negedge clk_i);
      k++;
    end
    chk("drain.out_valid", {31'd0, out_valid_o}, 32'd0);
    @(posedge clk_i);
    #1;
  endtask

  localparam logic [7:0] StrA[4] = '{8'h01, 8'h10, 8'h40, 8'h90};
  localparam logic [7:0] StrB[4] = '{8'h02, 8'h20, 8'h40, 8'h90};
  localparam logic [7:0] StrR[4] = '{8'h03, 8'h30, 8'h80, 8'h20};
  localparam logic [3:0] StrF[4] = '{4'b0000, 4'b0000, 4'b0011, 4'b1001};
  localparam logic       StrRdy[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
  localparam logic       StrIr[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

  initial begin
    int   lat;
    int   idx;
    exp_t e;

    repeat (2) @(posedge clk_i);
    #1;
    chk("reset.out", {24'd0, out_o}, 32'd0);
    chk("reset.out_hi", {24'd0, out_hi_o}, 32'd0);
    chk("reset.flags", {28'd0, flags_o}, 32'd0);
    chk("reset.out_valid", {31'd0, out_valid_o}, 32'd0);
    chk("reset.busy", {31'd0, busy_o}, 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("reset.in_ready", {31'd0, in_ready_o}, 32'd1);
    @(posedge clk_i);
    #1;

    // Leave non-zero flags behind so the mid-MUL reset has something to clear.
    issue("add_pre", OpAdd, 8'h80, 8'h80, 8'h00, 8'h00, 4'b1101, 1'b0, 1'b1);
    drain();
    issue("mul_abort", OpMul, 8'h03, 8'h04, 8'h00, 8'h00, 4'b0000, 1'b0, 1'b0);
    repeat (2) @(posedge clk_i);
    #2;
    chk("abort.busy_before", {31'd0, busy_o}, 32'd1);
    rst_ni = 1'b0;
    #1;
    chk("abort.out_valid", {31'd0, out_valid_o}, 32'd0);
    chk("abort.busy", {31'd0, busy_o}, 32'd0);
    chk("abort.flags", {28'd0, flags_o}, 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    issue("add_1_1", OpAdd, 8'h01, 8'h01, 8'h02, 8'h00, 4'b0000, 1'b0, 1'b1);

    issue("add_carry", OpAdd, 8'hFF, 8'h01, 8'h00, 8'h00, 4'b1100, 1'b0, 1'b1);
    issue("addc_chain", OpAddc, 8'h00, 8'h00, 8'h01, 8'h00, 4'b0000, 1'b0, 1'b1);
    issue("add_ovf", OpAdd, 8'h7F, 8'h01, 8'h80, 8'h00, 4'b0011, 1'b0, 1'b1);
    issue("sub_borrow", OpSub, 8'h03, 8'h05, 8'hFE, 8'h00, 4'b1010, 1'b0, 1'b1);
    issue("subb_chain", OpSubb, 8'h10, 8'h00, 8'h0F, 8'h00, 4'b0000, 1'b0, 1'b1);

    issue("sra_3", OpSra, 8'h80, 8'h03, 8'hF0, 8'h00, 4'b0010, 1'b0, 1'b1);
    issue("sra_sat", OpSra, 8'h80, 8'h09, 8'hFF, 8'h00, 4'b0010, 1'b0, 1'b1);
    issue("srl_sat", OpSrl, 8'h80, 8'h08, 8'h00, 8'h00, 4'b0100, 1'b0, 1'b1);
    issue("sll_7", OpSll, 8'h01, 8'h07, 8'h80, 8'h00, 4'b0010, 1'b0, 1'b1);
    issue("sll_lowbits", OpSll, 8'h01, 8'h11, 8'h02, 8'h00, 4'b0000, 1'b0, 1'b1);
    issue("add_setc", OpAdd, 8'hFF, 8'h02, 8'h01, 8'h00, 4'b1000, 1'b0, 1'b1);
    issue("and_keepc", OpAnd, 8'hF0, 8'h3C, 8'h30, 8'h00, 4'b1000, 1'b0, 1'b1);
    issue("xor", OpXor, 8'hAA, 8'hFF, 8'h55, 8'h00, 4'b1000, 1'b0, 1'b1);
    issue("not", OpNot, 8'h0F, 8'h00, 8'hF0, 8'h00, 4'b1010, 1'b0, 1'b1);
    issue("undef", OpUndef, 8'h12, 8'h34, 8'h00, 8'h00, 4'b1110, 1'b0, 1'b1);
    issue("or", OpOr, 8'h01, 8'h02, 8'h03, 8'h00, 4'b1000, 1'b0, 1'b1);

    // MUL with the consumer stalled: latency, busy and in_ready are tracked per cycle.
    drain();
    out_ready_i = 1'b0;
    issue("mul_ff", OpMul, 8'hFF, 8'hFF, 8'h01, 8'hFE, 4'b1000, 1'b0, 1'b1);
    lat = 0;
    for (int k = 1; k <= 12 && lat == 0; k++) begin
      @(negedge clk_i);
      chk($sformatf("mul.in_ready[%0d]", k), {31'd0, in_ready_o}, 32'd0);
      if (out_valid_o) begin
        lat = k;
      end else begin
        chk($sformatf("mul.busy[%0d]", k), {31'd0, busy_o}, 32'd1);
      end
    end
    chk("mul.latency", lat, 32'd9);
    @(negedge clk_i);
    chk("mul.hold_valid", {31'd0, out_valid_o}, 32'd1);
    chk("mul.hold_out", {24'd0, out_o}, 32'h01);
    chk("mul.hold_in_ready", {31'd0, in_ready_o}, 32'd0);
    @(posedge clk_i);
    #1;
    out_ready_i = 1'b1;
    @(negedge clk_i);
    chk("mul.release_in_ready", {31'd0, in_ready_o}, 32'd1);
    @(posedge clk_i);
    #1;

    // Streamed ADDs with out_ready stalling one cycle.
    drain();
    idx = 0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      out_ready_i = StrRdy[cyc];
      if (idx < 4) begin
        in_valid_i = 1'b1;
        op_i       = OpAdd;
        a_i        = StrA[idx];
        b_i        = StrB[idx];
      end else begin
        in_valid_i = 1'b0;
      end
      @(negedge clk_i);
      chk($sformatf("stream.in_ready[%0d]", cyc), {31'd0, in_ready_o}, {31'd0, StrIr[cyc]});
      if (in_valid_i && in_ready_o && idx < 4) begin
        e.name = $sformatf("stream%0d", idx);
        e.out  = StrR[idx];
        e.hi   = 8'h00;
        e.fl   = StrF[idx];
        sbq.push_back(e);
        idx++;
      end
      @(posedge clk_i);
      #1;
    end
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    chk("stream.issued", idx, 32'd4);
    issue("addc_clr", OpAddc, 8'h01, 8'h01, 8'h02, 8'h00, 4'b0000, 1'b1, 1'b1);

    drain();
    chk("scoreboard.empty", sbq.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test by 200000, want completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered ALU with a valid/ready handshake on both sides, a persistent flag register (C, Z, N, V) and an iterative multiplier.
- Sits between the decode stage and the register write-back stage.
- Adds behaviour a combinational ALU lacks: multi-word carry/borrow chaining across operations, signed overflow, arithmetic right shift, and a multi-cycle MUL with back-pressure.

Parameters:
- WIDTH, 8, operand/result width in bits; legal values 4..32.
- SHW, $clog2(WIDTH)+1, width of the shift-amount field taken from b.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operation presented.
- in_ready  out  1  block can accept an operation this cycle.
- op  in  4  ALU_OP code (enum in package).
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B; shifts use b[SHW-1:0].
- flag_clr  in  1  synchronous clear of C,Z,N,V; ignored while out_valid=1 and not consumed.
- out_valid  out  1  result register holds a result.
- out_ready  in  1  consumer takes result.
- out  out  WIDTH  result (low word for MUL).
- out_hi  out  WIDTH  MUL high word; 0 for all other ops.
- flags  out  4  {C,Z,N,V} after the result in out.
- busy  out  1  MUL iteration in progress.

Behaviour:
- Reset (async, rst_n=0):
  - out, out_hi, flags = 0; out_valid = 0; busy = 0; state = IDLE.
  - A multiply in progress is abandoned. The first accept is possible on the first clock after release.
- Handshake:
  - in_ready = (state==IDLE) && (!out_valid || out_ready).
  - Accept when in_valid && in_ready.
  - out_valid is held, with out/out_hi/flags stable, until out_valid && out_ready.
  - Back-to-back single-cycle ops sustain 1 op/cycle while out_ready=1.
- Latency:
  - Single-cycle ops: result registered on the accept edge; out_valid=1 the next cycle.
  - MUL: WIDTH cycles in BUSY, then the result registers. out_valid rises WIDTH+1 cycles after accept.
- States:
  - IDLE: accept ops; MUL goes to BUSY.
  - BUSY: shift-add one bit per cycle; count reaches WIDTH-1 → load result, go to IDLE.
  - in_ready=0 throughout BUSY. A previous result may still drain during BUSY.
  - If out_valid is still 1 on the final BUSY cycle and out_ready=0, stay in BUSY (result held in the multiplier) until the slot frees.
- Operations (C below is the stored carry flag):
  - ADD: {c,r} = a+b.
  - ADDC: {c,r} = a+b+C.
  - SUB: r = a-b; c = borrow (a<b unsigned).
  - SUBB: r = a-b-C; c = borrow.
  - SLL: r = a<<sh.
  - SRL: r = a>>sh (logical).
  - SRA: r = arithmetic right shift of a by sh.
  - Shift saturation: sh>=WIDTH gives 0 for SLL/SRL, and WIDTH copies of a[WIDTH-1] for SRA.
  - AND, OR, XOR: bitwise. NOT: ~a.
  - MUL: unsigned, {out_hi,out} = a*b.
  - Undefined codes: r=0, flags unchanged except Z=1.
- Flags (written with the result):
  - Z = (r==0). N = r[WIDTH-1].
  - C: carry/borrow for arithmetic ops; |out_hi for MUL; unchanged for logic and shift ops.
  - V: two's-complement overflow for ADD/ADDC/SUB/SUBB; 0 otherwise.
- flag_clr:
  - Applies at the edge it is sampled.
  - If an op is accepted on the same edge, the op sees C=0, and its resulting flags win.

Decomposition:
- Package ALU_def holds:
  - typedef enum logic[3:0] ALU_OP {ADD, ADDC, SUB, SUBB, SLL, SRL, SRA, AND, OR, XOR, NOT, MUL}.
  - typedef struct packed {c,z,n,v} alu_flags_t.
  - The state enum {IDLE, BUSY}.
- One sub-module: alu_mul_iter.
  - Parametrised by WIDTH, with start/done/hold, operands, {hi,lo} output and an internal counter.
  - Owns the BUSY iteration; the top holds the FSM, handshake and flag register.

Test Plan (WIDTH=8):
- Reset mid-MUL: rst_n low on BUSY cycle 3 → out_valid=0, busy=0, flags=0 immediately; next op ADD 1+1 → out=0x02, flags C=0,Z=0,N=0,V=0.
- Carry chain: ADD 0xFF+0x01 → out=0x00, C=1, Z=1; then ADDC 0x00+0x00 → out=0x01, C=0, Z=0.
- Overflow/borrow: ADD 0x7F+0x01 → 0x80, V=1, N=1; SUB 0x03-0x05 → 0xFE, C=1, N=1; SUBB 0x10-0x00 with C=1 → 0x0F, C=0.
- Shifts: SRA 0x80 by 3 → 0xF0; SRA 0x80 by 9 → 0xFF; SRL 0x80 by 8 → 0x00; SLL 0x01 by 7 → 0x80.
- MUL with back-pressure: MUL 0xFF*0xFF, out_ready=0 → out_valid rises 9 cycles after accept; out=0x01, out_hi=0xFE, C=1; in_ready=0 until out_ready=1.
- Throughput/stall: 4 ADDs streamed with out_ready toggling 1,0,1,1 → no result lost or duplicated; in_ready=0 exactly on stalled cycles; flag_clr together with ADDC 0x01+0x01 → out=0x02.
